// File: rtl/mem_map_pkg.sv
// Memory-map constants, arbiter state encoding and the access-legality rule
// shared by the arbiter and by every memory-map user.
package mem_map_pkg;

  localparam int MM_ADDR_W = 32;
  localparam int MM_DATA_W = 32;

  // RAM occupies [0, RAM_END); RAM_END itself is the read-only switch register.
  localparam logic [MM_ADDR_W-1:0] RAM_END   = 32'd27360;
  // Write-only GPIO latch.
  localparam logic [MM_ADDR_W-1:0] GPIO_ADDR = 32'd27361;
  // ROM is [GPIO_ADDR+1, ROM_END); everything at or above ROM_END is unmapped.
  localparam logic [MM_ADDR_W-1:0] ROM_END   = 32'd28082;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // True when an access must be kept off the memory bus.
  function automatic logic is_illegal(input logic [MM_ADDR_W-1:0] addr, input logic we);
    logic out_of_map;
    logic switch_write;
    logic rom_write;
    logic gpio_read;
    out_of_map   = (addr >= ROM_END);
    switch_write = we && (addr == RAM_END);
    rom_write    = we && (addr > GPIO_ADDR) && (addr < ROM_END);
    gpio_read    = !we && (addr == GPIO_ADDR);
    return out_of_map || switch_write || rom_write || gpio_read;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response handshake and shared memory bus of the two-port arbiter.
// slave is the arbiter side; master is the requesters plus the memory map.
interface mem_arbiter_if
  import mem_map_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
);

  // Requests: index 0 is the CPU data port, index 1 is the DMA/loader.
  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;

  // Responses.
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // Shared memory-map port; mem_rdata is combinational from mem_addr.
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick. With both ports asking, the port
// that did not receive the previous grant wins; a lone requester always wins.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic [1:0] gnt_onehot
);

  // Grant decode from the request pair and the previous winner.
  always_comb begin
    gnt_onehot = 2'b00;
    case (valid)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      2'b11:   gnt_onehot = last_gnt ? 2'b01 : 2'b10;
      default: gnt_onehot = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory-map port between the CPU data port and the DMA.
// One request is accepted per handshake, the bus is driven for exactly one
// cycle, and the response pulses on the following cycle. Illegal accesses
// are answered with an error and never reach the memory map.
module mem_arbiter
  import mem_map_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_reg,     state_next;
  logic              last_gnt_reg,  last_gnt_next;
  logic              cur_port_reg,  cur_port_next;
  logic              cur_we_reg,    cur_we_next;
  logic [ADDR_W-1:0] cur_addr_reg,  cur_addr_next;
  logic [DATA_W-1:0] cur_wdata_reg, cur_wdata_next;
  logic              cur_err_reg,   cur_err_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

  logic [1:0]        pick_valid;
  logic [1:0]        gnt_onehot;
  logic              win_port;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              mem_drive;

  // Arbitration is only open outside ACCESS, and never while reset is held,
  // so no ready pulse can leak out during reset.
  assign pick_valid = (rst_n && (state_reg != ACCESS)) ? bus.req_valid : 2'b00;

  rr_pick2 u_pick (
    .valid      (pick_valid),
    .last_gnt   (last_gnt_reg),
    .gnt_onehot (gnt_onehot)
  );

  // The bus is driven only in ACCESS and only for a legal access; it is
  // decoded from registers alone so mem_rdata cannot loop back into it.
  assign mem_drive     = (state_reg == ACCESS) && !cur_err_reg;
  assign bus.mem_addr  = mem_drive ? cur_addr_reg  : '0;
  assign bus.mem_we    = mem_drive ? cur_we_reg    : 1'b0;
  assign bus.mem_wdata = mem_drive ? cur_wdata_reg : '0;

  // State and transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      last_gnt_reg  <= 1'b1;
      cur_port_reg  <= 1'b0;
      cur_we_reg    <= 1'b0;
      cur_addr_reg  <= '0;
      cur_wdata_reg <= '0;
      cur_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      last_gnt_reg  <= last_gnt_next;
      cur_port_reg  <= cur_port_next;
      cur_we_reg    <= cur_we_next;
      cur_addr_reg  <= cur_addr_next;
      cur_wdata_reg <= cur_wdata_next;
      cur_err_reg   <= cur_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // Next-state, grant latching and handshake outputs.
  always_comb begin
    state_next     = state_reg;
    last_gnt_next  = last_gnt_reg;
    cur_port_next  = cur_port_reg;
    cur_we_next    = cur_we_reg;
    cur_addr_next  = cur_addr_reg;
    cur_wdata_next = cur_wdata_reg;
    cur_err_next   = cur_err_reg;
    rsp_rdata_next = rsp_rdata_reg;

    bus.req_ready  = 2'b00;
    bus.rsp_valid  = 2'b00;
    bus.rsp_err    = 1'b0;
    bus.rsp_rdata  = rsp_rdata_reg;

    // Payload of whichever port the picker chose this cycle.
    win_port  = gnt_onehot[1];
    win_we    = win_port ? bus.req_we[1]  : bus.req_we[0];
    win_addr  = win_port ? bus.req_addr1  : bus.req_addr0;
    win_wdata = win_port ? bus.req_wdata1 : bus.req_wdata0;

    case (state_reg)
      IDLE, RESP: begin
        if (state_reg == RESP) begin
          bus.rsp_valid = cur_port_reg ? 2'b10 : 2'b01;
          bus.rsp_err   = cur_err_reg;
        end
        if (gnt_onehot != 2'b00) begin
          bus.req_ready  = gnt_onehot;
          cur_port_next  = win_port;
          cur_we_next    = win_we;
          cur_addr_next  = win_addr;
          cur_wdata_next = win_wdata;
          cur_err_next   = is_illegal(win_addr, win_we);
          last_gnt_next  = win_port;
          state_next     = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end

      ACCESS: begin
        // Writes and rejected accesses both answer with zero data.
        if (!cur_err_reg && !cur_we_reg) begin
          rsp_rdata_next = bus.mem_rdata;
        end else begin
          rsp_rdata_next = '0;
        end
        state_next = RESP;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory-map port (RAM, switch register, GPIO, ROM) between the processor data port and a second bus master (DMA/loader). It accepts one request at a time per valid/ready handshake, drives the shared memory bus for exactly one cycle, and returns read data with a per-request response pulse. It also rejects illegal accesses before they reach the memory map.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RAM_END, 27360, first address past RAM; also the switch register address
- GPIO_ADDR, 27361, GPIO write address
- ROM_END, 28082, first unmapped address; ROM is [GPIO_ADDR+1, ROM_END)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid[1:0]  in  2  request valid; index 0 is the CPU, index 1 is the DMA
- req_we[1:0]  in  2  write enable, per port
- req_addr0, req_addr1  in  ADDR_W  request addresses
- req_wdata0, req_wdata1  in  DATA_W  write data
- req_ready[1:0]  out  2  accept pulse, one cycle, one-hot or zero
- rsp_valid[1:0]  out  2  response pulse, one cycle
- rsp_rdata  out  DATA_W  response data, qualified by rsp_valid
- rsp_err  out  1  response error flag, qualified by rsp_valid
- mem_addr  out  ADDR_W  shared memory address
- mem_we  out  1  shared memory write enable
- mem_wdata  out  DATA_W  shared memory write data
- mem_rdata  in  DATA_W  shared memory read data, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration happens in IDLE and RESP. It uses round-robin over the valid requests:
  - The last_gnt register holds the most recent grant and resets to 1, so the CPU wins the first tie.
  - With both ports valid, the port other than last_gnt wins.
  - With one port valid, that port wins.
- On a win:
  - req_ready[winner] pulses for that cycle.
  - The winner's we/addr/wdata are latched into cur_*.
  - The illegal check is evaluated and latched into cur_err.
  - The next state is ACCESS.
  - last_gnt takes the winner.
- With no request valid, the next state is IDLE.
- An access is illegal if any of these holds:
  - addr ≥ ROM_END
  - a write to RAM_END (read-only switch)
  - a write in the ROM range
  - a read of GPIO_ADDR
- ACCESS:
  - Legal access: drive mem_addr = cur_addr, mem_we = cur_we, mem_wdata = cur_wdata. Capture mem_rdata into rsp_rdata, or 0 for writes.
  - Illegal access: mem_we = 0, mem_addr = 0, rsp_rdata = 0.
  - The next state is always RESP.
- RESP:
  - rsp_valid[cur_port] = 1 and rsp_err = cur_err.
  - Arbitrate as in IDLE. A win goes directly to ACCESS; otherwise the next state is IDLE.
- Outside ACCESS, mem_addr = 0, mem_we = 0 and mem_wdata = 0. The memory bus is therefore quiet and the GPIO latch cannot be spuriously written.
- Requesters hold valid and payload stable until they see ready. Dropping valid before ready is allowed and cancels the request.

## Timing
- Reset values, applied asynchronously while rst_n is low:
  - state = IDLE, last_gnt = 1, cur_* = 0, rsp_rdata = 0.
  - All outputs are 0, including req_ready, rsp_valid, rsp_err and mem_*.
- Latency: request seen at edge N → ready during cycle N → bus driven in cycle N+1 → rsp_valid in cycle N+2.
- Throughput: with continuous demand, one grant every 2 cycles. With both ports saturated, grants alternate strictly: 0, 1, 0, 1, …
- Only one mem_we cycle per accepted write, never more.
- Asserting rst_n low mid-ACCESS or mid-RESP aborts the transaction:
  - no rsp_valid is issued
  - mem_we drops immediately
  - the requester reissues after reset
- A simultaneous new request on the port that currently holds RESP is legal. That port competes under round-robin, so it loses to a valid other port.

## Structure
- Shared package mem_map_pkg holds:
  - the address constants RAM_END, GPIO_ADDR, ROM_END
  - the state enum arb_state_e {IDLE, ACCESS, RESP}
  - the function is_illegal(addr, we)
- Memory-map users import the same package.
- Sub-module rr_pick2: a combinational 2-way round-robin pick taking valid[1:0] and last_gnt, producing gnt_onehot.
- The rest of the logic sits in one always_ff and one always_comb.

## Test plan
- Single CPU read of addr 100 with mem_rdata = 0xDEADBEEF → ready0 at N, mem_addr = 100 at N+1, rsp_valid0 with rdata 0xDEADBEEF and err = 0 at N+2.
- Both ports continuously valid, reads of 10 and 20, for 8 grants → ready order 0,1,0,1,0,1,0,1. Grants are 2 cycles apart and mem_addr alternates 10/20.
- DMA write of 0x1 to GPIO_ADDR → mem_we = 1 for exactly one cycle with mem_addr = 27361, then rsp_valid1 with err = 0 and rdata = 0.
- Illegal cases: CPU write to 27400 (ROM), then a read of 28082, then a write to 27360 → mem_we stays 0 throughout, each response has err = 1 and rdata = 0.
- rst_n pulsed low during ACCESS of a write → mem_we drops the same cycle, no rsp_valid appears, all outputs are 0, and after release the first tie goes to port 0.
- Valid dropped before ready (port 1 valid for one cycle while the FSM is in ACCESS) → no grant to port 1 and no memory access for it.
